// File: rtl/rab_miss_fifo.sv
// Miss-handling FIFO behind the RAB core: buffers {address, ID} of each miss until software
// pops it through the register read path, and counts misses dropped while full.
module rab_miss_fifo #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned MISS_ID_WIDTH = 10,
  parameter int unsigned OVF_CNT_WIDTH = 16
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic                         Miss_SI,
  input  logic [31:0]                  MissAddr_DI,
  input  logic [MISS_ID_WIDTH-1:0]     MissId_DI,
  input  logic                         RdAddr_SI,
  input  logic                         RdId_SI,
  output logic [31:0]                  RdData_DO,
  output logic                         MhFifoFull_SO,
  output logic                         MhFifoEmpty_SO,
  output logic [$clog2(FIFO_DEPTH):0]  Count_DO,
  output logic [OVF_CNT_WIDTH-1:0]     OvfCnt_DO,
  input  logic                         ClrOvf_SI
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [31:0]              addr_mem_q [FIFO_DEPTH];
  logic [MISS_ID_WIDTH-1:0] id_mem_q   [FIFO_DEPTH];
  logic [31:0]              rd_data_q, rd_data_d;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            empty, full;
  logic            pop, push, drop;
  logic [31:0]     head_addr;
  logic [31:0]     id_word;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];

  // Extra pointer MSB separates the full case from the empty case at equal indices.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

  // A pop frees the head slot, so a miss arriving at full is still accepted.
  assign pop  = RdId_SI & ~empty;
  assign push = Miss_SI & (~full | pop);
  assign drop = Miss_SI & full & ~pop;

  assign head_addr = addr_mem_q[rd_idx];

  always_comb begin
    id_word                      = '0;
    id_word[MISS_ID_WIDTH-1:0]   = id_mem_q[rd_idx];
    id_word[31]                  = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (RdId_SI) begin
      rd_data_d = empty ? 32'h0 : id_word;
    end else if (RdAddr_SI) begin
      rd_data_d = empty ? 32'h0 : head_addr;
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ClrOvf_SI) begin
      ovf_cnt_d = drop ? OVF_CNT_WIDTH'(1) : '0;
    end else if (drop && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge s_axi_aclk) begin
    if (push) begin
      addr_mem_q[wr_idx] <= MissAddr_DI;
      id_mem_q[wr_idx]   <= MissId_DI;
    end
  end

  assign RdData_DO      = rd_data_q;
  assign MhFifoEmpty_SO = empty;
  assign MhFifoFull_SO  = full;
  assign Count_DO       = wr_ptr_q - rd_ptr_q;
  assign OvfCnt_DO      = ovf_cnt_q;

endmodule
